if_stage: RTL

- Instruction-fetch stage feeding the decode/execute stage of the LoongArch32 core.
- Owns the PC register and issues requests to the synchronous instruction SRAM, which has a 1-cycle read latency.
- Holds the fetched instruction under a valid/allowin handshake, with a 1-entry buffer that captures SRAM data during downstream stalls.
- Redirects on branch/jump resolution from the downstream stage and cancels the wrong-path fetch.

---
 rtl/if_stage_if.sv | 49 ++++
 rtl/if_stage.sv | 72 +++++++
 2 files changed

// File: rtl/if_stage_if.sv
// Bundle between the fetch stage, the instruction SRAM and the decode stage:
// SRAM request/response, fs->ds valid/allowin handshake and branch redirect.
interface if_stage_if;
    // instruction SRAM
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    // downstream handshake and redirect
    logic        ds_allowin;
    logic        br_taken;
    logic [31:0] br_target;
    logic        fs_to_ds_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        fs_excp_adef;

    modport master (
        output inst_sram_en,
        output inst_sram_we,
        output inst_sram_addr,
        output inst_sram_wdata,
        input  inst_sram_rdata,
        input  ds_allowin,
        input  br_taken,
        input  br_target,
        output fs_to_ds_valid,
        output fs_pc,
        output fs_inst,
        output fs_excp_adef
    );

    modport slave (
        input  inst_sram_en,
        input  inst_sram_we,
        input  inst_sram_addr,
        input  inst_sram_wdata,
        output inst_sram_rdata,
        output ds_allowin,
        output br_taken,
        output br_target,
        input  fs_to_ds_valid,
        input  fs_pc,
        input  fs_inst,
        input  fs_excp_adef
    );
endinterface

// File: rtl/if_stage.sv
// LoongArch32 instruction-fetch stage: PC register, 1-cycle-latency SRAM fetch,
// 1-entry stall buffer and branch redirect. Optional macro IF_ADEF_CHECK_EN.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic       clk,
    input  logic       resetn,
    if_stage_if.master bus
);

    logic        fs_valid_reg;
    logic        buf_valid_reg;
    logic [31:0] inst_buf_reg;
    logic [31:0] fs_pc_reg;
    logic        fs_adef_reg;

    logic [31:0] seq_pc;
    logic [31:0] nextpc;
    logic        fs_allowin;
    logic        fs_stall;
    logic        nextpc_adef;

    assign seq_pc     = fs_pc_reg + 32'd4;
    assign nextpc     = bus.br_taken ? bus.br_target : seq_pc;
    assign fs_allowin = ~fs_valid_reg | bus.ds_allowin | bus.br_taken;
    assign fs_stall   = ~fs_allowin;

`ifdef IF_ADEF_CHECK_EN
    // A misaligned PC still occupies a pipeline slot so the fault reaches decode.
    assign nextpc_adef = |nextpc[1:0];
`else
    assign nextpc_adef = 1'b0;
`endif

    assign bus.inst_sram_en    = resetn & fs_allowin & ~nextpc_adef;
    assign bus.inst_sram_we    = 4'b0;
    assign bus.inst_sram_addr  = nextpc;
    assign bus.inst_sram_wdata = 32'b0;

    assign bus.fs_to_ds_valid = fs_valid_reg & ~bus.br_taken;
    assign bus.fs_pc          = fs_pc_reg;
    assign bus.fs_excp_adef   = fs_valid_reg & fs_adef_reg;

    always_comb begin
        bus.fs_inst = bus.inst_sram_rdata;
        if (fs_adef_reg) begin
            bus.fs_inst = 32'h0;
        end else if (buf_valid_reg) begin
            bus.fs_inst = inst_buf_reg;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fs_valid_reg  <= 1'b0;
            buf_valid_reg <= 1'b0;
            inst_buf_reg  <= 32'h0;
            fs_pc_reg     <= RESET_PC - 32'd4;
            fs_adef_reg   <= 1'b0;
        end else if (fs_allowin) begin
            fs_pc_reg     <= nextpc;
            fs_valid_reg  <= 1'b1;
            buf_valid_reg <= 1'b0;
            fs_adef_reg   <= nextpc_adef;
        end else if (fs_stall && !buf_valid_reg) begin
            // SRAM output is only valid for one cycle; park it for the stall.
            inst_buf_reg  <= bus.inst_sram_rdata;
            buf_valid_reg <= 1'b1;
        end
    end

endmodule
